// File: rtl/rv_types.sv
// rv_types: shared state encoding and defaults for the rv32 memory arbiter
package rv_types;
  typedef enum logic [1:0] {LATCH, DACC, IACC, DONE} arb_state_t;
  localparam logic [7:0]  TIMEOUT_DEF = 8'd255;
  localparam logic [31:0] ERRDATA_DEF = 32'h0000_0073;
endpackage

// File: rtl/rv_fetch_buf.sv
// rv_fetch_buf: one-word instruction fetch buffer with tag compare
//   fill, fill_ok, fill_tag, fill_word : load a fetched word; it becomes valid only if fill_ok
//   inval, inval_tag                   : drop the buffered word when a store hits its tag
//   look_tag -> hit, word              : lookup for the current fetch address
module rv_fetch_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        fill,
  input  logic        fill_ok,
  input  logic [29:0] fill_tag,
  input  logic [31:0] fill_word,
  input  logic        inval,
  input  logic [29:0] inval_tag,
  input  logic [29:0] look_tag,
  output logic        hit,
  output logic [31:0] word
);
  logic        valid;
  logic [29:0] tag;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      word  <= '0;
    end else if (fill) begin
      valid <= fill_ok;
      tag   <= fill_tag;
      word  <= fill_word;
    end else if (inval && tag == inval_tag) begin
      valid <= 1'b0;
    end
  end
  assign hit = valid & (tag == look_tag);
endmodule

// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shares one variable-latency memory between the core's fetch and data ports
//   i_adr, i_re -> i_dr, i_rdy                 : fetch port
//   d_adr, d_re, d_we, d_dw -> d_dr, d_rdy      : load/store port (d_rdy mirrors i_rdy)
//   m_adr, m_req, m_we, m_dw <- m_dr, m_ack     : memory port, one access at a time
//   err                                         : sticky flag, set when an access times out
module rv_mem_arb
  import rv_types::*;
#(
  parameter logic [7:0]  TIMEOUT = TIMEOUT_DEF,
  parameter logic [31:0] ERRDATA = ERRDATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_adr,
  input  logic        i_re,
  output logic [31:0] i_dr,
  output logic        i_rdy,
  input  logic [31:0] d_adr,
  input  logic        d_re,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_dw,
  output logic [31:0] d_dr,
  output logic        d_rdy,
  output logic [31:0] m_adr,
  output logic        m_req,
  output logic [3:0]  m_we,
  output logic [31:0] m_dw,
  input  logic [31:0] m_dr,
  input  logic        m_ack,
  output logic        err
);
  arb_state_t  state, nxt;
  logic        need_i, need_d_now, need_i_now, refetch, hit, to_hit, done_acc, m_req_n;
  logic [7:0]  wcnt;
  logic [31:0] d_q, rdata, fb_word, m_adr_n, m_dw_n;
  logic [3:0]  m_we_n;
  logic        unused_ok;
  assign unused_ok = ^{i_adr[1:0], d_adr[1:0]};
  rv_fetch_buf u_fb (
    .clk(clk), .reset(reset),
    .fill(state == IACC && done_acc), .fill_ok(m_ack), .fill_tag(i_adr[31:2]), .fill_word(rdata),
    .inval(state == DACC && done_acc && d_we != 4'b0), .inval_tag(d_adr[31:2]),
    .look_tag(i_adr[31:2]), .hit(hit), .word(fb_word)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= LATCH;
      m_req  <= 1'b0;
      m_adr  <= '0;
      m_we   <= '0;
      m_dw   <= '0;
      i_rdy  <= 1'b0;
      err    <= 1'b0;
      need_i <= 1'b0;
      d_q    <= '0;
      wcnt   <= '0;
    end else begin
      state  <= nxt;
      m_req  <= m_req_n;
      m_adr  <= m_adr_n;
      m_we   <= m_we_n;
      m_dw   <= m_dw_n;
      i_rdy  <= nxt == DONE;
      err    <= err | to_hit;
      need_i <= state == LATCH ? need_i_now : need_i;
      d_q    <= state == LATCH ? '0 : (state == DACC && done_acc && d_we == 4'b0) ? rdata : d_q;
      wcnt   <= m_req ? wcnt + 8'd1 : 8'd0;
    end
  end
  // A store to the word being fetched forces a fresh fetch even if it hit at LATCH.
  always_comb begin
    need_d_now = d_re | (d_we != 4'b0);
    need_i_now = i_re & ~hit;
    refetch    = i_re & (d_we != 4'b0) & (d_adr[31:2] == i_adr[31:2]);
    to_hit     = m_req & ~m_ack & (wcnt == TIMEOUT);
    done_acc   = (m_req & m_ack) | to_hit;
    nxt = state == LATCH ? (need_d_now ? DACC : need_i_now ? IACC : DONE) :
          state == DACC  ? (done_acc ? ((need_i | refetch) ? IACC : DONE) : DACC) :
          state == IACC  ? (done_acc ? DONE : IACC) : LATCH;
  end
  // A fetch following a data access waits one idle cycle in IACC so m_req always drops between accesses.
  always_comb begin
    rdata   = m_ack ? m_dr : ERRDATA;
    m_req_n = state == LATCH ? nxt != DONE :
              state == DACC  ? ~done_acc :
              state == IACC  ? (~m_req | ~done_acc) : 1'b0;
    m_adr_n = nxt == IACC ? {i_adr[31:2], 2'b00} : nxt == DACC ? {d_adr[31:2], 2'b00} : m_adr;
    m_we_n  = nxt == DACC ? d_we : 4'b0;
    m_dw_n  = nxt == DACC ? d_dw : m_dw;
  end
  assign d_rdy = i_rdy;
  assign i_dr  = i_rdy ? fb_word : '0;
  assign d_dr  = i_rdy ? d_q : '0;
endmodule

// File: tb/tb_rv_mem_arb.sv
// tb_rv_mem_arb: randomized and directed checks of rv_mem_arb against a transaction-level model
module tb_rv_mem_arb;
  import rv_types::*;
  localparam logic [7:0] TO = 8'd8;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] i_adr = '0, d_adr = '0, d_dw = '0, m_dr = '0;
  logic i_re = 1'b0, d_re = 1'b0, m_ack = 1'b0;
  logic [3:0] d_we = '0;
  logic [31:0] i_dr, d_dr, m_adr, m_dw;
  logic i_rdy, d_rdy, m_req, err;
  logic [3:0] m_we;
  rv_mem_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .i_adr(i_adr), .i_re(i_re), .i_dr(i_dr), .i_rdy(i_rdy),
    .d_adr(d_adr), .d_re(d_re), .d_we(d_we), .d_dw(d_dw), .d_dr(d_dr), .d_rdy(d_rdy),
    .m_adr(m_adr), .m_req(m_req), .m_we(m_we), .m_dw(m_dw), .m_dr(m_dr), .m_ack(m_ack), .err(err)
  );
  always #5 clk = ~clk;
  int vecs = 0, miss = 0;
  logic [31:0] mem [int];
  int ack_dly = 1;
  bit no_ack = 1'b0;
  logic [35:0] acc_log [$];
  int unstable = 0;
  bit fb_v = 1'b0, exp_err = 1'b0;
  logic [29:0] fb_t = '0;
  logic [31:0] fb_w = '0, exp_i, exp_d;
  int exp_cyc;
  logic [35:0] exp_acc [$];
  int obs_cyc;
  logic [31:0] obs_i, obs_d;
  logic obs_drdy, obs_next, obs_err;
  function automatic logic [31:0] rd(input logic [29:0] w);
    return mem.exists(int'(w)) ? mem[int'(w)] : ({w[15:0] * 16'd40503, w[15:0]} ^ 32'h1357_9bdf);
  endfunction
  // memory: acks ack_dly cycles after m_req rises, logs every access, applies stores on ack
  initial begin : responder
    bit busy;
    int n;
    logic [31:0] a, w;
    logic [3:0] we;
    busy = 1'b0; n = 0; a = '0; we = '0;
    forever begin
      @(posedge clk); #1;
      m_ack = 1'b0;
      if (m_req) begin
        if (!busy) begin
          busy = 1'b1; n = 0; a = m_adr; we = m_we;
          acc_log.push_back({we, a});
        end else if (m_adr !== a || m_we !== we) unstable++;
        if (!no_ack && n == ack_dly) begin
          w = rd(a[31:2]);
          m_ack = 1'b1; m_dr = w;
          for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = m_dw[8*b +: 8];
          if (we != 4'b0) mem[int'(a[31:2])] = w;
          busy = 1'b0;
        end else n++;
      end else busy = 1'b0;
    end
  end
  // reference: data op first, then fetch unless the (possibly invalidated) buffer holds the word
  task automatic model(input bit fe, input bit ld, input logic [3:0] we);
    int acc;
    bit dat, fetch;
    logic [29:0] dt, it;
    logic [31:0] w;
    acc = (no_ack ? int'(TO) : ack_dly) + 1;
    dat = ld || we != 4'b0;
    dt = d_adr[31:2]; it = i_adr[31:2];
    exp_acc.delete(); exp_cyc = 2; exp_d = '0;
    if (dat) begin
      exp_acc.push_back({we, dt, 2'b00});
      exp_cyc += acc;
      if (ld && we == 4'b0) exp_d = no_ack ? ERRDATA_DEF : rd(dt);
      if (we != 4'b0 && fb_v && fb_t == dt) fb_v = 1'b0;
    end
    fetch = fe && !(fb_v && fb_t == it);
    if (fetch) begin
      exp_acc.push_back({4'b0, it, 2'b00});
      exp_cyc += acc + (dat ? 1 : 0);
      w = rd(it);
      if (we != 4'b0 && dt == it) for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = d_dw[8*b +: 8];
      if (no_ack) w = ERRDATA_DEF;
      fb_t = it; fb_w = w; fb_v = !no_ack;
    end
    exp_i = fb_w;
    if (no_ack && (dat || fetch)) exp_err = 1'b1;
  endtask
  task automatic txn(input bit fe, input bit ld, input logic [3:0] we,
                     input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw);
    i_re = fe; d_re = ld; d_we = we; i_adr = ia; d_adr = da; d_dw = dw;
    model(fe, ld, we);
    acc_log.delete();
    obs_cyc = 1;
    do begin @(posedge clk); #1; obs_cyc++; end while (!i_rdy && obs_cyc < 400);
    obs_i = i_dr; obs_d = d_dr; obs_drdy = d_rdy; obs_err = err;
    @(posedge clk); #1;
    obs_next = i_rdy;
  endtask
  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    vecs++; if ({i_rdy, d_rdy, m_req, err} !== 4'b0) begin miss++; $display("FAIL reset_flags got %b exp 0000", {i_rdy, d_rdy, m_req, err}); end
    vecs++; if ({m_adr, m_dw, m_we} !== 68'b0) begin miss++; $display("FAIL reset_bus got %h exp 0", {m_adr, m_dw, m_we}); end
    vecs++; if ({i_dr, d_dr} !== 64'b0) begin miss++; $display("FAIL reset_data got %h exp 0", {i_dr, d_dr}); end
    fb_v = 1'b0; fb_w = '0; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask
  task automatic test_fetch_only;
    mem[32'h100 / 4] = 32'h0000_0013; ack_dly = 1; no_ack = 1'b0;
    txn(1'b1, 1'b0, 4'b0, 32'h100, 32'h0, 32'h0);
    vecs++; if (obs_cyc != 4) begin miss++; $display("FAIL fetch_only_cycles got %0d exp 4", obs_cyc); end
    vecs++; if (obs_i !== 32'h13) begin miss++; $display("FAIL fetch_only_i_dr got %h exp 00000013", obs_i); end
    vecs++; if (acc_log.size() != 1 || acc_log[0] !== {4'b0, 32'h100}) begin miss++; $display("FAIL fetch_only_access got %0d accesses exp one read at 100", acc_log.size()); end
    vecs++; if (obs_next !== 1'b0) begin miss++; $display("FAIL fetch_only_rdy_pulse got %b exp 0", obs_next); end
  endtask
  task automatic test_compressed;
    mem[32'h200 / 4] = 32'ha5a5_0001;
    txn(1'b1, 1'b0, 4'b0, 32'h200, 32'h0, 32'h0);
    vecs++; if (obs_i !== 32'ha5a5_0001) begin miss++; $display("FAIL compr_first got %h exp a5a50001", obs_i); end
    txn(1'b1, 1'b0, 4'b0, 32'h202, 32'h0, 32'h0);
    vecs++; if (acc_log.size() != 0) begin miss++; $display("FAIL compr_no_access got %0d exp 0", acc_log.size()); end
    vecs++; if (obs_cyc != 2) begin miss++; $display("FAIL compr_cycles got %0d exp 2", obs_cyc); end
    vecs++; if (obs_i !== 32'ha5a5_0001) begin miss++; $display("FAIL compr_i_dr got %h exp a5a50001", obs_i); end
  endtask
  task automatic test_load_fetch;
    mem[32'h1004 / 4] = 32'hdead_beef; mem[32'h104 / 4] = 32'h0000_0513; ack_dly = 3;
    txn(1'b1, 1'b1, 4'b0, 32'h104, 32'h1004, 32'h0);
    vecs++; if (acc_log.size() != 2) begin miss++; $display("FAIL ldf_count got %0d exp 2", acc_log.size()); end
    vecs++; if (acc_log.size() > 0 && acc_log[0] !== {4'b0, 32'h1004}) begin miss++; $display("FAIL ldf_first got %h exp 000001004", acc_log[0]); end
    vecs++; if (acc_log.size() > 1 && acc_log[1] !== {4'b0, 32'h104}) begin miss++; $display("FAIL ldf_second got %h exp 000000104", acc_log[1]); end
    vecs++; if (obs_d !== 32'hdead_beef) begin miss++; $display("FAIL ldf_d_dr got %h exp deadbeef", obs_d); end
    vecs++; if (obs_i !== 32'h0000_0513) begin miss++; $display("FAIL ldf_i_dr got %h exp 00000513", obs_i); end
    vecs++; if (obs_drdy !== 1'b1 || obs_next !== 1'b0) begin miss++; $display("FAIL ldf_rdy got d_rdy=%b next=%b exp 1 0", obs_drdy, obs_next); end
    vecs++; if (obs_cyc != exp_cyc) begin miss++; $display("FAIL ldf_cycles got %0d exp %0d", obs_cyc, exp_cyc); end
  endtask
  task automatic test_store_inval;
    ack_dly = 1;
    txn(1'b1, 1'b0, 4'b0, 32'h200, 32'h0, 32'h0);
    txn(1'b0, 1'b0, 4'b0011, 32'h0, 32'h200, 32'h1122_3344);
    vecs++; if (acc_log.size() != 1 || acc_log[0] !== {4'b0011, 32'h200}) begin miss++; $display("FAIL st_access got %0d accesses exp one write we=3 at 200", acc_log.size()); end
    vecs++; if (obs_d !== 32'h0) begin miss++; $display("FAIL st_d_dr got %h exp 0", obs_d); end
    txn(1'b1, 1'b0, 4'b0, 32'h200, 32'h0, 32'h0);
    vecs++; if (acc_log.size() != 1) begin miss++; $display("FAIL st_refetch got %0d accesses exp 1", acc_log.size()); end
    vecs++; if (obs_i !== 32'ha5a5_3344) begin miss++; $display("FAIL st_i_dr got %h exp a5a53344", obs_i); end
  endtask
  task automatic test_timeout;
    no_ack = 1'b1;
    txn(1'b1, 1'b0, 4'b0, 32'h300, 32'h0, 32'h0);
    vecs++; if (obs_i !== 32'h0000_0073) begin miss++; $display("FAIL to_i_dr got %h exp 00000073", obs_i); end
    vecs++; if (obs_cyc != 11) begin miss++; $display("FAIL to_cycles got %0d exp 11", obs_cyc); end
    vecs++; if (obs_err !== 1'b1) begin miss++; $display("FAIL to_err got %b exp 1", obs_err); end
    no_ack = 1'b0; ack_dly = 2;
    txn(1'b1, 1'b0, 4'b0, 32'h300, 32'h0, 32'h0);
    vecs++; if (acc_log.size() != 1) begin miss++; $display("FAIL to_no_fill got %0d accesses exp 1", acc_log.size()); end
    vecs++; if (obs_i !== exp_i) begin miss++; $display("FAIL to_refetch_i_dr got %h exp %h", obs_i, exp_i); end
    vecs++; if (obs_err !== 1'b1) begin miss++; $display("FAIL to_err_sticky got %b exp 1", obs_err); end
  endtask
  task automatic test_reset_mid;
    ack_dly = 5;
    i_re = 1'b1; i_adr = 32'h300; d_re = 1'b1; d_adr = 32'h1000; d_we = 4'b0;
    @(posedge clk); #1;
    vecs++; if (m_req !== 1'b1 || m_adr !== 32'h1000) begin miss++; $display("FAIL rstmid_dacc got req=%b adr=%h exp 1 00001000", m_req, m_adr); end
    #2 reset = 1'b1;
    #1;
    vecs++; if ({m_req, i_rdy, err} !== 3'b0) begin miss++; $display("FAIL rstmid_async got %b exp 000", {m_req, i_rdy, err}); end
    fb_v = 1'b0; fb_w = '0; exp_err = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    ack_dly = 1;
    txn(1'b1, 1'b0, 4'b0, 32'h300, 32'h0, 32'h0);
    vecs++; if (acc_log.size() != 1 || acc_log[0] !== {4'b0, 32'h300}) begin miss++; $display("FAIL rstmid_refetch got %0d accesses exp one read at 300", acc_log.size()); end
    vecs++; if (obs_i !== exp_i) begin miss++; $display("FAIL rstmid_i_dr got %h exp %h", obs_i, exp_i); end
  endtask
  task automatic test_random;
    bit fe, ld;
    logic [3:0] we;
    int op;
    for (int t = 0; t < 60; t++) begin
      ack_dly = $urandom_range(1, 3);
      no_ack = $urandom_range(0, 11) == 0;
      fe = $urandom_range(0, 3) != 0;
      op = $urandom_range(0, 2);
      ld = op == 1;
      we = op == 2 ? 4'($urandom_range(1, 15)) : 4'b0;
      txn(fe, ld, we, 32'h100 + 32'($urandom_range(0, 7)) * 2,
          32'h100 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3)), $urandom);
      vecs++; if (obs_cyc != exp_cyc) begin miss++; $display("FAIL rnd%0d_cycles got %0d exp %0d", t, obs_cyc, exp_cyc); end
      vecs++; if (obs_i !== exp_i) begin miss++; $display("FAIL rnd%0d_i_dr got %h exp %h", t, obs_i, exp_i); end
      vecs++; if (obs_d !== exp_d) begin miss++; $display("FAIL rnd%0d_d_dr got %h exp %h", t, obs_d, exp_d); end
      vecs++; if (obs_drdy !== 1'b1 || obs_next !== 1'b0) begin miss++; $display("FAIL rnd%0d_rdy got d_rdy=%b next=%b exp 1 0", t, obs_drdy, obs_next); end
      vecs++; if (obs_err !== exp_err) begin miss++; $display("FAIL rnd%0d_err got %b exp %b", t, obs_err, exp_err); end
      vecs++; if (acc_log.size() != exp_acc.size()) begin miss++; $display("FAIL rnd%0d_acc_count got %0d exp %0d", t, acc_log.size(), exp_acc.size()); end
      else foreach (exp_acc[k]) begin
        vecs++; if (acc_log[k] !== exp_acc[k]) begin miss++; $display("FAIL rnd%0d_acc%0d got %h exp %h", t, k, acc_log[k], exp_acc[k]); end
      end
    end
    no_ack = 1'b0;
    vecs++; if (unstable != 0) begin miss++; $display("FAIL bus_stable got %0d changes exp 0", unstable); end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_fetch_only;
    test_compressed;
    test_load_fetch;
    test_store_inval;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
